// File: rtl/pipelined_decode_controller.sv
// pipelined_decode_controller
// Buffered instruction decoder: a valid/ready input queue feeds a decode stage
// whose result sits in an ID/EX output register with its own valid/ready
// handshake. Load-use hazards against the instruction held in the output
// register insert a single bubble.
//
// Optional feature macro: CTRL_HAZARD_STALL_EN
//   defined   -> load-use detection, bubble insertion, hazardStall/stallCount live
//   undefined -> heads decode back-to-back, hazardStall and stallCount tied to 0
//
// Handshake rules (both sides): a transfer happens on a clock edge where
// valid and ready are both high. instrReady depends only on reset and queue
// occupancy. outValid, once high, holds the bundle stable until outReady.
module pipelined_decode_controller #(
  parameter int FIFO_DEPTH     = 4,
  parameter int REG_ID_WIDTH   = 5,
  parameter int ALU_CODE_WIDTH = 4,
  parameter int ZERO_REG       = 31
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          instrValid,
  input  logic [31:0]                   instruction,
  output logic                          instrReady,
  input  logic                          flush,
  input  logic                          outReady,
  output logic                          outValid,
  output logic [2:0]                    opType,
  output logic [ALU_CODE_WIDTH-1:0]     aluControlCode,
  output logic [REG_ID_WIDTH-1:0]       readRegister1,
  output logic [REG_ID_WIDTH-1:0]       readRegister2,
  output logic [REG_ID_WIDTH-1:0]       writeRegister,
  output logic [6:0]                    ctrlFlags,
  output logic                          hazardStall,
  output logic [7:0]                    stallCount,
  output logic [$clog2(FIFO_DEPTH):0]   fifoCount
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [2:0] OP_LD = 3'd0;
  localparam logic [2:0] OP_CB = 3'd1;
  localparam logic [2:0] OP_R  = 3'd2;
  localparam logic [2:0] OP_ST = 3'd3;
  localparam logic [2:0] OP_I  = 3'd4;
  localparam logic [2:0] OP_B  = 3'd5;
  localparam logic [2:0] OP_M  = 3'd6;

  // ---------------------------------------------------------------------------
  // Input queue
  // ---------------------------------------------------------------------------
  logic [31:0]      mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             fifo_empty;
  logic             push;
  logic             pop;
  logic             load_en;
  logic             hazard;
  logic [31:0]      head;

  assign fifo_empty = (count_q == '0);
  // A full queue refuses a push even when a pop frees a slot this cycle.
  assign instrReady = !reset && (count_q < CNT_W'(FIFO_DEPTH));
  assign push       = instrValid && instrReady && !flush;
  assign load_en    = (!outValid || outReady) && !flush;
  assign pop        = load_en && !fifo_empty && !hazard;
  assign head       = mem_q[rd_ptr_q];
  assign fifoCount  = count_q;

  // Pointer and occupancy next-state; flush empties the queue outright.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // Queue pointers and occupancy.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Queue storage; contents need no reset because occupancy gates every read.
  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q] <= instruction;
  end

  // ---------------------------------------------------------------------------
  // Decode of the queue head
  // ---------------------------------------------------------------------------
  logic [2:0]              dec_op;
  logic [3:0]              dec_alu;
  logic [REG_ID_WIDTH-1:0] dec_rr1;
  logic [REG_ID_WIDTH-1:0] dec_rr2;
  logic [REG_ID_WIDTH-1:0] dec_wr;
  logic [6:0]              dec_flags;
  logic                    reg2_loc;

  // Instruction class, register IDs, ALU code and datapath flags.
  always_comb begin
    dec_op = OP_I;
    if (head[26])       dec_op = head[29] ? OP_CB : OP_B;
    else if (!head[28]) dec_op = OP_R;
    else if (head[23])  dec_op = OP_M;
    else if (head[22])  dec_op = OP_LD;
    else if (head[27])  dec_op = OP_ST;

    reg2_loc = (dec_op == OP_CB) || (dec_op == OP_ST);
    dec_rr1  = REG_ID_WIDTH'(head[9:5]);
    dec_rr2  = reg2_loc ? REG_ID_WIDTH'(head[4:0]) : REG_ID_WIDTH'(head[20:16]);
    dec_wr   = REG_ID_WIDTH'(head[4:0]);

    dec_alu = 4'd0;
    case (dec_op)
      OP_LD, OP_ST: dec_alu = 4'd2;
      OP_CB:        dec_alu = 4'd7;
      OP_M:         dec_alu = 4'd13;
      OP_B:         dec_alu = 4'd0;
      OP_R: begin
        if (head[24])       dec_alu = head[30] ? 4'd10 : 4'd2;
        else if (!head[29]) dec_alu = 4'd6;
        else if (!head[30]) dec_alu = 4'd4;
        else                dec_alu = 4'd9;
      end
      OP_I: begin
        if (head[29])      dec_alu = 4'd4;
        else if (head[30]) dec_alu = head[25] ? 4'd9 : 4'd10;
        else               dec_alu = head[25] ? 4'd6 : 4'd2;
      end
      default: dec_alu = 4'd0;
    endcase

    // {unconditionalBranch, branch, memRead, memToReg, memWrite, aluSRC, regWriteFlag}
    dec_flags = {
      dec_op == OP_B,
      dec_op == OP_CB,
      dec_op == OP_LD,
      dec_op == OP_LD,
      dec_op == OP_ST,
      !((dec_op == OP_R) || (dec_op == OP_CB)),
      (dec_op == OP_R) || (dec_op == OP_LD) || (dec_op == OP_M)
    };
  end

  // Instruction bits that no decode field looks at.
  logic unused_head_bits;
  assign unused_head_bits = ^{head[31], head[21], head[15:10]};

  // ---------------------------------------------------------------------------
  // ID/EX output register
  // ---------------------------------------------------------------------------
  logic                      out_valid_q;
  logic [2:0]                out_op_q;
  logic [ALU_CODE_WIDTH-1:0] out_alu_q;
  logic [REG_ID_WIDTH-1:0]   out_rr1_q;
  logic [REG_ID_WIDTH-1:0]   out_rr2_q;
  logic [REG_ID_WIDTH-1:0]   out_wr_q;
  logic [6:0]                out_flags_q;

  // Load the head's decode on pop; a bubble or empty queue only clears valid.
  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_op_q    <= '0;
      out_alu_q   <= '0;
      out_rr1_q   <= '0;
      out_rr2_q   <= '0;
      out_wr_q    <= '0;
      out_flags_q <= '0;
    end else if (flush) begin
      out_valid_q <= 1'b0;
    end else if (load_en) begin
      out_valid_q <= pop;
      if (pop) begin
        out_op_q    <= dec_op;
        out_alu_q   <= ALU_CODE_WIDTH'(dec_alu);
        out_rr1_q   <= dec_rr1;
        out_rr2_q   <= dec_rr2;
        out_wr_q    <= dec_wr;
        out_flags_q <= dec_flags;
      end
    end
  end

  assign outValid       = out_valid_q;
  assign opType         = out_op_q;
  assign aluControlCode = out_alu_q;
  assign readRegister1  = out_rr1_q;
  assign readRegister2  = out_rr2_q;
  assign writeRegister  = out_wr_q;
  assign ctrlFlags      = out_flags_q;

  // ---------------------------------------------------------------------------
  // Load-use hazard handling
  // ---------------------------------------------------------------------------
`ifdef CTRL_HAZARD_STALL_EN
  logic       stall_now;
  logic       hazard_stall_q;
  logic [7:0] stall_cnt_q;

  // A valid load in the output register whose destination the head reads;
  // the zero register is never a hazard source.
  assign hazard = out_valid_q && (out_op_q == OP_LD)
               && (out_wr_q != REG_ID_WIDTH'(ZERO_REG))
               && ((dec_rr1 == out_wr_q) || (dec_rr2 == out_wr_q));

  // A bubble is only counted when the output register would have loaded.
  assign stall_now = load_en && !fifo_empty && hazard;

  // Bubble indicator follows each output-register load; flush clears it.
  always_ff @(posedge clock) begin
    if (reset)        hazard_stall_q <= 1'b0;
    else if (flush)   hazard_stall_q <= 1'b0;
    else if (load_en) hazard_stall_q <= stall_now;
  end

  // Saturating bubble counter; flush leaves it untouched.
  always_ff @(posedge clock) begin
    if (reset)                               stall_cnt_q <= 8'd0;
    else if (stall_now && stall_cnt_q != 8'hFF) stall_cnt_q <= stall_cnt_q + 8'd1;
  end

  assign hazardStall = hazard_stall_q;
  assign stallCount  = stall_cnt_q;
`else
  assign hazard      = 1'b0;
  assign hazardStall = 1'b0;
  assign stallCount  = 8'd0;

  logic unused_hazard_src;
  assign unused_hazard_src = (out_wr_q == REG_ID_WIDTH'(ZERO_REG));
`endif

endmodule

// File: tb/tb_pipelined_decode_controller.sv
// Testbench for pipelined_decode_controller: directed scenarios followed by
// randomized traffic, all checked against a transaction-level reference model
// (instruction queue + decoded output bundle).
module tb_pipelined_decode_controller;

  localparam int DEPTH = 4;

  typedef struct packed {
    logic [2:0] op;
    logic [3:0] alu;
    logic [4:0] r1;
    logic [4:0] r2;
    logic [4:0] wr;
    logic [6:0] flags;
  } fields_t;

  // ---------------- clock / reset ----------------
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        instrValid = 1'b0;
  logic [31:0] instruction = '0;
  logic        instrReady;
  logic        flush = 1'b0;
  logic        outReady = 1'b0;
  logic        outValid;
  logic [2:0]  opType;
  logic [3:0]  aluControlCode;
  logic [4:0]  readRegister1;
  logic [4:0]  readRegister2;
  logic [4:0]  writeRegister;
  logic [6:0]  ctrlFlags;
  logic        hazardStall;
  logic [7:0]  stallCount;
  logic [2:0]  fifoCount;

  always #5 clock = ~clock;

  pipelined_decode_controller dut (
    .clock          (clock),
    .reset          (reset),
    .instrValid     (instrValid),
    .instruction    (instruction),
    .instrReady     (instrReady),
    .flush          (flush),
    .outReady       (outReady),
    .outValid       (outValid),
    .opType         (opType),
    .aluControlCode (aluControlCode),
    .readRegister1  (readRegister1),
    .readRegister2  (readRegister2),
    .writeRegister  (writeRegister),
    .ctrlFlags      (ctrlFlags),
    .hazardStall    (hazardStall),
    .stallCount     (stallCount),
    .fifoCount      (fifoCount)
  );

  // ---------------- scoreboard / reference model ----------------
  int unsigned total = 0;
  int unsigned bad   = 0;

  logic [31:0] exp_q[$];       // instructions waiting in the input queue
  logic        m_valid = 1'b0; // output bundle valid
  fields_t     m_f     = '0;   // output bundle fields
  logic        m_stall = 1'b0;
  int          m_cnt   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Decode written directly from the instruction-class rules.
  function automatic fields_t ref_decode(input logic [31:0] w);
    fields_t f;
    if (w[26])       f.op = w[29] ? 3'd1 : 3'd5;
    else if (!w[28]) f.op = 3'd2;
    else if (w[23])  f.op = 3'd6;
    else if (w[22])  f.op = 3'd0;
    else if (w[27])  f.op = 3'd3;
    else             f.op = 3'd4;
    case (f.op)
      3'd0, 3'd3: f.alu = 4'd2;
      3'd1:       f.alu = 4'd7;
      3'd6:       f.alu = 4'd13;
      3'd2:       f.alu = w[24] ? (w[30] ? 4'd10 : 4'd2) : (!w[29] ? 4'd6 : (!w[30] ? 4'd4 : 4'd9));
      3'd4:       f.alu = w[29] ? 4'd4 : (w[30] ? (w[25] ? 4'd9 : 4'd10) : (w[25] ? 4'd6 : 4'd2));
      default:    f.alu = 4'd0;
    endcase
    f.r1 = w[9:5];
    f.r2 = (f.op == 3'd1 || f.op == 3'd3) ? w[4:0] : w[20:16];
    f.wr = w[4:0];
    f.flags = {f.op == 3'd5, f.op == 3'd1, f.op == 3'd0, f.op == 3'd0, f.op == 3'd3,
               !(f.op == 3'd2 || f.op == 3'd1),
               (f.op == 3'd2 || f.op == 3'd0 || f.op == 3'd6)};
    return f;
  endfunction

  function automatic logic ref_hazard();
    fields_t h;
`ifdef CTRL_HAZARD_STALL_EN
    if (exp_q.size() == 0 || !m_valid || m_f.op != 3'd0 || m_f.wr == 5'd31) return 1'b0;
    h = ref_decode(exp_q[0]);
    return (h.r1 == m_f.wr) || (h.r2 == m_f.wr);
`else
    h = '0;
    return h.op[0];
`endif
  endfunction

  // Advance the model by one clock edge given the inputs applied at that edge.
  task automatic model_edge(input logic v, input logic [31:0] w, input logic ordy,
                            input logic fl, input logic rst);
    logic ready_pre;
    logic haz;
    if (rst) begin
      exp_q.delete();
      m_valid = 1'b0; m_f = '0; m_stall = 1'b0; m_cnt = 0;
    end else if (fl) begin
      exp_q.delete();
      m_valid = 1'b0; m_stall = 1'b0;
    end else begin
      ready_pre = (exp_q.size() < DEPTH);
      haz = ref_hazard();
      if (!m_valid || ordy) begin
        if (exp_q.size() > 0 && !haz) begin
          m_f = ref_decode(exp_q.pop_front());
          m_valid = 1'b1; m_stall = 1'b0;
        end else if (exp_q.size() > 0) begin
          m_valid = 1'b0; m_stall = 1'b1;
          if (m_cnt < 255) m_cnt++;
        end else begin
          m_valid = 1'b0; m_stall = 1'b0;
        end
      end
      if (v && ready_pre) exp_q.push_back(w);
    end
  endtask

  task automatic compare_all();
    check("fifoCount",   32'(fifoCount),   32'(exp_q.size()));
    check("outValid",    32'(outValid),    32'(m_valid));
    check("opType",      32'(opType),      32'(m_f.op));
    check("aluCode",     32'(aluControlCode), 32'(m_f.alu));
    check("readReg1",    32'(readRegister1), 32'(m_f.r1));
    check("readReg2",    32'(readRegister2), 32'(m_f.r2));
    check("writeReg",    32'(writeRegister), 32'(m_f.wr));
    check("ctrlFlags",   32'(ctrlFlags),   32'(m_f.flags));
    check("hazardStall", 32'(hazardStall), 32'(m_stall));
    check("stallCount",  32'(stallCount),  32'(m_cnt));
  endtask

  // ---------------- driver ----------------
  // Called #1 after a rising edge; applies inputs, checks ready, clocks once.
  task automatic step(input logic v, input logic [31:0] w, input logic ordy,
                      input logic fl, input logic rst);
    instrValid = v; instruction = w; outReady = ordy; flush = fl; reset = rst;
    #1;
    check("instrReady", 32'(instrReady), 32'(!rst && exp_q.size() < DEPTH));
    @(posedge clock);
    model_edge(v, w, ordy, fl, rst);
    #1;
    compare_all();
  endtask

  function automatic logic [4:0] rnd_reg();
    return ($urandom_range(0, 4) == 0) ? 5'd31 : 5'($urandom_range(0, 3));
  endfunction

  function automatic logic [31:0] rnd_instr();
    logic [31:0] w;
    w = $urandom;
    if ($urandom_range(0, 9) < 3) begin
      w[26] = 1'b0; w[28] = 1'b1; w[23] = 1'b0; w[22] = 1'b1;   // load
    end
    w[4:0] = rnd_reg(); w[9:5] = rnd_reg(); w[20:16] = rnd_reg();
    return w;
  endfunction

  // ---------------- stimulus ----------------
  localparam logic [31:0] ADD_X0  = 32'h8B020020;
  localparam logic [31:0] LDUR_X3 = 32'hF8400083;
  localparam logic [31:0] ADD_X5  = 32'h8B060065;
  localparam logic [31:0] LD_X31  = 32'hF840009F;
  localparam logic [31:0] RD_X31  = 32'h8B0603E5;
  localparam logic [31:0] CBZ_X7  = 32'hB4000047;

  initial begin
    @(posedge clock); #1;
    step(0, '0, 0, 0, 1);
    step(0, '0, 0, 0, 1);
    check("reset_outValid", 32'(outValid), 32'd0);
    check("reset_fifoCount", 32'(fifoCount), 32'd0);

    // Single ADD: visible one edge after the push edge.
    step(1, ADD_X0, 1, 0, 0);
    check("add_latency_outValid", 32'(outValid), 32'd0);
    step(0, '0, 1, 0, 0);
    check("add_outValid", 32'(outValid), 32'd1);
    check("add_opType", 32'(opType), 32'd2);
    check("add_alu", 32'(aluControlCode), 32'd2);
    check("add_rr1", 32'(readRegister1), 32'd1);
    check("add_rr2", 32'(readRegister2), 32'd2);
    check("add_wr", 32'(writeRegister), 32'd0);
    check("add_flags", 32'(ctrlFlags), 32'h01);

    // Fill while downstream stalls; the head moves into the output register first.
    step(0, '0, 0, 0, 1);
    for (int i = 0; i < 5; i++) step(1, ADD_X0 + 32'(i + 1), 0, 0, 0);
    check("full_fifoCount", 32'(fifoCount), 32'd4);
    step(1, 32'h8B02002F, 0, 0, 0);    // refused: queue full
    check("full_instrReady", 32'(instrReady), 32'd0);
    for (int i = 0; i < 6; i++) step(0, '0, 1, 0, 0);

    // Load-use hazard.
    step(0, '0, 0, 0, 1);
    step(1, LDUR_X3, 1, 0, 0);
    step(1, ADD_X5, 1, 0, 0);
    step(0, '0, 1, 0, 0);
`ifdef CTRL_HAZARD_STALL_EN
    check("haz_bubble_valid", 32'(outValid), 32'd0);
    check("haz_bubble_stall", 32'(hazardStall), 32'd1);
    check("haz_bubble_count", 32'(stallCount), 32'd1);
    step(0, '0, 1, 0, 0);
`endif
    check("haz_add_valid", 32'(outValid), 32'd1);
    check("haz_add_op", 32'(opType), 32'd2);
    check("haz_add_wr", 32'(writeRegister), 32'd5);

    // Load to the zero register never stalls.
    step(0, '0, 0, 0, 1);
    step(1, LD_X31, 1, 0, 0);
    step(1, RD_X31, 1, 0, 0);
    step(0, '0, 1, 0, 0);
    check("x31_no_stall", 32'(hazardStall), 32'd0);
    check("x31_rr1", 32'(readRegister1), 32'd31);

    // Flush with a simultaneous push.
    step(0, '0, 0, 0, 1);
    for (int i = 0; i < 4; i++) step(1, ADD_X0, 0, 0, 0);
    check("pre_flush_count", 32'(fifoCount), 32'd3);
    step(1, ADD_X5, 0, 1, 0);
    check("flush_count", 32'(fifoCount), 32'd0);
    check("flush_valid", 32'(outValid), 32'd0);
    step(0, '0, 1, 0, 0);
    check("flush_dropped", 32'(outValid), 32'd0);

    // CBZ, then reset mid-stream.
    step(1, CBZ_X7, 1, 0, 0);
    step(1, ADD_X0, 0, 0, 0);
    check("cbz_op", 32'(opType), 32'd1);
    check("cbz_alu", 32'(aluControlCode), 32'd7);
    check("cbz_rr2", 32'(readRegister2), 32'd7);
    check("cbz_flags", 32'(ctrlFlags), 32'h20);
    step(0, '0, 0, 0, 1);
    check("midreset_op", 32'(opType), 32'd0);
    check("midreset_flags", 32'(ctrlFlags), 32'd0);

    // Randomized traffic.
    step(0, '0, 0, 0, 0);
    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(0, 9) < 7, rnd_instr(), $urandom_range(0, 9) < 6,
           $urandom_range(0, 99) < 3, $urandom_range(0, 199) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
